// File: rtl/csa_addsub_seq.sv
// Sequential carry-select adder/subtractor: walks the operands one SLICE-bit
// slice per clock, LSB first, with valid/ready handshakes on both sides.
module csa_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int NPAD   = 1 << IDXW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_sl [NPAD];
  logic [SLICE-1:0] b_sl [NPAD];
  logic [SLICE:0]   s0, s1, s;
  logic             last_slice;

  // Slice tables padded to a power of two so idx_q can index them directly.
  always_comb begin
    for (int k = 0; k < NPAD; k++) begin
      a_sl[k] = '0;
      b_sl[k] = '0;
      if (k < NSLICE) begin
        a_sl[k] = a_q[k*SLICE +: SLICE];
        b_sl[k] = b_q[k*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    s0         = {1'b0, a_sl[idx_q]} + {1'b0, b_sl[idx_q]};
    s1         = {1'b0, a_sl[idx_q]} + {1'b0, b_sl[idx_q]} + {{SLICE{1'b0}}, 1'b1};
    s          = carry_q ? s1 : s0;
    last_slice = (idx_q == IDXW'(NSLICE - 1));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction becomes a + ~b + 1 with the +1 entering as carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        for (int k = 0; k < NSLICE; k++) begin
          if (IDXW'(k) == idx_q) sum_d[k*SLICE +: SLICE] = s[SLICE-1:0];
        end
        carry_d = s[SLICE];
        idx_d   = idx_q + IDXW'(1);
        if (last_slice) begin
          cout_d  = s[SLICE];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_addsub_seq.sv
// Self-checking bench for csa_addsub_seq: directed corner cases, backpressure,
// mid-run reset and random operands against an arithmetic reference model.
module tb_csa_addsub_seq;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, busy;

  int errors = 0;
  int checks = 0;

  csa_addsub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic msub, output logic [WIDTH-1:0] es,
                                output logic ec, output logic eo);
    longint sa, sb, r;
    logic [WIDTH:0] wide;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      es = ma - mb;
      ec = (ma >= mb);
      r  = sa - sb;
    end else begin
      wide = {1'b0, ma} + {1'b0, mb};
      es   = wide[WIDTH-1:0];
      ec   = wide[WIDTH];
      r    = sa + sb;
    end
    eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Presents operands and returns at the negedge following the accept edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                input logic tsub);
    int w;
    @(negedge clk);
    a = ta; b = tb_; sub = tsub; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_output("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'(($urandom));
    check_output("busy_after_accept", busy, 1);
    check_output("in_ready_after_accept", in_ready, 0);
    check_output("out_valid_after_accept", out_valid, 0);
  endtask

  // Waits for the result, checks latency/values, holds backpressure, then handshakes.
  task automatic finish_op(input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                           input int hold);
    int lat;
    logic [WIDTH-1:0] s_snap;
    logic c_snap, o_snap;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_output("latency", 64'(lat), 64'(NSLICE));
    check_output("sum", sum, es);
    check_output("cout", cout, ec);
    check_output("ovf", ovf, eo);
    s_snap = sum; c_snap = cout; o_snap = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_output("hold_out_valid", out_valid, 1);
      check_output("hold_in_ready", in_ready, 0);
      check_output("hold_sum", sum, s_snap);
      check_output("hold_flags", {cout, ovf}, {c_snap, o_snap});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_after_handshake", out_valid, 0);
    check_output("in_ready_after_handshake", in_ready, 1);
    check_output("busy_after_handshake", busy, 0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tsub, input int hold);
    logic [WIDTH-1:0] es;
    logic ec, eo;
    model(ta, tb_, tsub, es, ec, eo);
    apply_stimulus(ta, tb_, tsub);
    finish_op(es, ec, eo, hold);
  endtask

  initial begin
    logic [WIDTH-1:0] es, ra, rb;
    logic ec, eo, rs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_sum", sum, 0);
    check_output("reset_cout", cout, 0);
    check_output("reset_ovf", ovf, 0);
    check_output("reset_busy", busy, 0);

    run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b0, 0);
    run_op(32'h00000007, 32'h00000005, 1'b1, 0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 2);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0);

    // Absolute values for the spec's corner cases, independent of the model.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
    check_output("abs_carry_slice_sum", sum, 32'h00000100);
    run_op(32'h00000005, 32'h00000007, 1'b1, 0);
    check_output("abs_sub_neg_sum", {cout, sum}, {1'b0, 32'hFFFFFFFE});

    // Backpressure with a competing operand set waiting on in_valid.
    model(32'h12345678, 32'h0F0F0F0F, 1'b0, es, ec, eo);
    apply_stimulus(32'h12345678, 32'h0F0F0F0F, 1'b0);
    in_valid = 1'b1; a = 32'h1; b = 32'h1; sub = 1'b0;
    finish_op(es, ec, eo, 10);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("pending_accepted_busy", busy, 1);
    finish_op(32'h2, 1'b0, 1'b0, 0);

    // Reset after slice 1 has been processed.
    apply_stimulus(32'hDEADBEEF, 32'h01234567, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("midreset_out_valid", out_valid, 0);
    check_output("midreset_sum", sum, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_in_ready", in_ready, 1);
    check_output("midreset_flags", {cout, ovf}, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("midreset_no_result", out_valid, 0);
    end

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 6 == 0) ra = {1'b1, {(WIDTH-1){1'b0}}};
      if (n % 6 == 1) rb = {1'b0, {(WIDTH-1){1'b1}}};
      if (n % 6 == 2) rb = ra;
      run_op(ra, rb, rs, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
